prio_grant_arbiter: RTL
=======================

Name: prio_grant_arbiter

Overview:
- Fixed-priority arbiter that shares one resource among N_REQ requesters.
- Priority order follows a priority if / else-if chain: lowest index wins.
- Once granted, the owner holds the resource until it releases, drops its request, or hits a hold-time limit.
- Sits between requesting masters and a single shared datapath. It is the sequencer that decides ownership each arbitration.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- HOLD_MAX, 8, maximum consecutive grant cycles per ownership (>=1).
- AGE_LIMIT, 3, lost-arbitration count at which a requester is promoted. Used only with ARB_AGING_EN.

Ports:
- clk  in  1  single clock; all state is updated on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester request level.
- rel  in  1  release strobe from the current owner.
- gnt  out  N_REQ  one-hot grant; all-zero when no owner.
- gnt_id  out  $clog2(N_REQ)  index of the current owner; 0 when idle.
- gnt_vld  out  1  high while a grant is active (equals |gnt).
- timeout  out  1  one-cycle pulse when a grant is ended by HOLD_MAX.

Behaviour:
- Reset (async, rst_n=0): the state machine goes to IDLE, and all outputs clear immediately with no clock edge needed.
  - gnt=0, gnt_id=0, gnt_vld=0, timeout=0.
  - Hold counter = 0 and all age counters = 0.
- Reset applied mid-grant: the grant is dropped asynchronously, with no GAP cycle and no timeout pulse.
- The state machine has three states: IDLE, GRANT, GAP. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, the winner is the lowest set index of req.
  - Next cycle: state=GRANT, gnt=onehot(winner), gnt_id=winner, hold counter=1.
  - Latency from req to gnt is 1 cycle.
- GRANT: the grant ends when any one of these occurs in the current cycle:
  - rel=1, or
  - req[gnt_id]=0, or
  - hold counter==HOLD_MAX.
- When the grant ends, the next cycle is GAP with gnt=0. Otherwise the hold counter increments; its width is $clog2(HOLD_MAX+1) and it never wraps.
- The grant lasts at most HOLD_MAX cycles.
- timeout=1 during the GAP cycle only when the end was caused solely by the hold limit.
  - If rel=1 or req dropped in the same cycle as the limit, timeout=0 (release takes precedence).
- GAP: lasts exactly one cycle with gnt=0, then IDLE. This gives a minimum 1-cycle bubble between owners.
- Requests are never preempted: a higher-priority req arriving during GRANT waits for the next IDLE.
- rel is ignored in IDLE and GAP.
- gnt is always one-hot or zero, and gnt_vld==|gnt in every cycle.

Optional Feature:
- Macro: ARB_AGING_EN.
- With the macro defined:
  - Each requester has a saturating wait counter of width $clog2(AGE_LIMIT+1).
  - At each IDLE->GRANT decision, the counter increments for every requester with req=1 that did not win.
  - The counter clears when that requester is granted, or whenever its req=0.
  - At arbitration, if any requester has a counter >= AGE_LIMIT, the winner is the lowest index among those aged requesters. Otherwise the normal priority order applies.
- Without the macro: pure fixed priority. No age counters exist and AGE_LIMIT is unused.

Decomposition:
- Package prio_arb_pkg contains:
  - typedef enum logic [1:0] arb_state_e {IDLE, GRANT, GAP};
  - localparam helper function for id width ($clog2 wrapper with a minimum of 1).
- One sub-module: prio_enc.
  - Parameterised N-bit lowest-index priority encoder.
  - Outputs: found, index, onehot.
  - Instantiated once for the normal request vector. With ARB_AGING_EN, it is instantiated a second time for the aged mask.

Test Plan:
- rst_n=0 held 3 cycles with req=4'b1111 -> gnt=0, gnt_id=0, gnt_vld=0, timeout=0 throughout.
- IDLE, req=4'b1010 at edge t -> at t+1 gnt=4'b0010, gnt_id=1, gnt_vld=1.
- Owner req1 asserts rel on its 3rd grant cycle, with req=4'b1010 held -> next cycle gnt=0 (GAP), timeout=0. Following cycle is IDLE; req1 is re-granted (lowest index), gnt=4'b0010.
- HOLD_MAX=8, req=4'b0001 held, no rel -> gnt=4'b0001 for exactly 8 cycles, then GAP with timeout=1 for 1 cycle, then re-grant.
- Grant active on req2, drive rst_n=0 between clock edges -> gnt, gnt_vld and gnt_id drop to 0 immediately. After release, IDLE re-arbitrates on the first edge.
- ARB_AGING_EN, AGE_LIMIT=3, req=4'b1001 held, owner pulses rel on each grant's first cycle -> arbitrations 1-3 grant req0, and the 4th arbitration grants req3 (gnt=4'b1000).

Source files
------------

// File: rtl/prio_arb_pkg.sv
// Shared types and width helpers for the fixed-priority grant arbiter.
package prio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // $clog2 that never returns less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Parameterised lowest-index priority encoder: found flag, binary index and one-hot.
module prio_enc
  import prio_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  vec,
  output logic          found,
  output logic [IW-1:0] index,
  output logic [N-1:0]  onehot
);

  assign found  = |vec;
  assign onehot = vec & (~vec + N'(1));

  // Scan from the top down so the lowest set bit is the last one kept.
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      index = vec[i] ? IW'(i) : index;
    end
  end

endmodule

// File: rtl/prio_grant_arbiter.sv
// Fixed-priority arbiter with hold-time limit and a one-cycle bubble between owners.
// Optional starvation aging is enabled by defining ARB_AGING_EN.
module prio_grant_arbiter
  import prio_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int HOLD_MAX  = 8,
  parameter int AGE_LIMIT = 3,
  localparam int IW       = clog2_min1(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_id,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam int CW = clog2_min1(HOLD_MAX + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX);

  if (N_REQ < 2 || N_REQ > 16 || HOLD_MAX < 1 || AGE_LIMIT < 1) begin : g_bad_param
    $error("prio_grant_arbiter: parameter out of range");
  end

  arb_state_e          state_r, state_s;
  logic [N_REQ-1:0]    gnt_r, gnt_s;
  logic [IW-1:0]       gnt_id_r, gnt_id_s;
  logic                gnt_vld_r, gnt_vld_s;
  logic                timeout_r, timeout_s;
  logic [CW-1:0]       hold_r, hold_s;
  logic                req_found_s;
  logic [IW-1:0]       req_idx_s, win_idx_s;
  logic [N_REQ-1:0]    req_oh_s, win_oh_s;
  logic                drop_s, limit_s;

  prio_enc #(.N(N_REQ), .IW(IW)) u_req_enc (
    .vec(req), .found(req_found_s), .index(req_idx_s), .onehot(req_oh_s)
  );

`ifdef ARB_AGING_EN
  localparam int AW = clog2_min1(AGE_LIMIT + 1);
  localparam logic [AW-1:0] AGE_THR = AW'(AGE_LIMIT);
  localparam logic [AW-1:0] AGE_SAT = {AW{1'b1}};

  logic [AW-1:0]    age_r [N_REQ];
  logic [N_REQ-1:0] aged_vec_s, aged_oh_s;
  logic [IW-1:0]    aged_idx_s;
  logic             aged_found_s;
  logic             arb_s;

  // Requesters that are asking and have waited long enough to jump the queue.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      aged_vec_s[i] = req[i] & (age_r[i] >= AGE_THR);
    end
  end

  prio_enc #(.N(N_REQ), .IW(IW)) u_aged_enc (
    .vec(aged_vec_s), .found(aged_found_s), .index(aged_idx_s), .onehot(aged_oh_s)
  );

  assign win_idx_s = aged_found_s ? aged_idx_s : req_idx_s;
  assign win_oh_s  = aged_found_s ? aged_oh_s  : req_oh_s;
  assign arb_s     = (state_r == IDLE) && req_found_s;

  // Wait counters: bump losers at each arbitration, clear on win or idle request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) age_r[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!req[i] || (arb_s && win_oh_s[i])) age_r[i] <= '0;
        else if (arb_s && age_r[i] != AGE_SAT) age_r[i] <= age_r[i] + AW'(1);
        else age_r[i] <= age_r[i];
      end
    end
  end
`else
  assign win_idx_s = req_idx_s;
  assign win_oh_s  = req_oh_s;
`endif

  assign drop_s  = rel | ~req[gnt_id_r];
  assign limit_s = (hold_r == HOLD_LAST);

  // Next-state and next-output decode for the IDLE / GRANT / GAP sequencer.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    gnt_id_s  = gnt_id_r;
    gnt_vld_s = gnt_vld_r;
    timeout_s = 1'b0;
    hold_s    = hold_r;
    case (state_r)
      IDLE: begin
        if (req_found_s) begin
          state_s   = GRANT;
          gnt_s     = win_oh_s;
          gnt_id_s  = win_idx_s;
          gnt_vld_s = 1'b1;
          hold_s    = CW'(1);
        end else begin
          state_s   = IDLE;
          gnt_s     = '0;
          gnt_id_s  = '0;
          gnt_vld_s = 1'b0;
          hold_s    = '0;
        end
      end
      GRANT: begin
        if (drop_s || limit_s) begin
          state_s   = GAP;
          gnt_s     = '0;
          gnt_id_s  = '0;
          gnt_vld_s = 1'b0;
          hold_s    = '0;
          timeout_s = limit_s & ~drop_s;
        end else begin
          hold_s    = hold_r + CW'(1);
        end
      end
      GAP: begin
        state_s   = IDLE;
        gnt_s     = '0;
        gnt_id_s  = '0;
        gnt_vld_s = 1'b0;
        hold_s    = '0;
      end
      default: begin
        state_s   = IDLE;
        gnt_s     = '0;
        gnt_id_s  = '0;
        gnt_vld_s = 1'b0;
        hold_s    = '0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      gnt_r     <= '0;
      gnt_id_r  <= '0;
      gnt_vld_r <= 1'b0;
      timeout_r <= 1'b0;
      hold_r    <= '0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      gnt_id_r  <= gnt_id_s;
      gnt_vld_r <= gnt_vld_s;
      timeout_r <= timeout_s;
      hold_r    <= hold_s;
    end
  end

  assign gnt     = gnt_r;
  assign gnt_id  = gnt_id_r;
  assign gnt_vld = gnt_vld_r;
  assign timeout = timeout_r;

endmodule
